truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N, default 4, meaning DUT input width (legal 1..8).
REQ-002 SHALL have parameter DWELL, default 5, meaning clock cycles each vector is held (legal >=1).
REQ-003 SHALL have parameter GAP, default 12, meaning idle cycles inserted at the half-table midpoint (legal >=0).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a sweep; sampled only in IDLE.
REQ-007 SHALL have port mode  input  1  sweep direction, captured with start: 0 ascending, 1 descending.
REQ-008 SHALL have port abort  input  1  terminate the sweep in progress.
REQ-009 SHALL have port f_in  input  1  DUT response to vec.
REQ-010 SHALL have port vec  output  N  stimulus vector to the DUT.
REQ-011 SHALL have port vec_valid  output  1  vec is a live stimulus (high only in DRIVE).
REQ-012 SHALL have port busy  output  1  high in DRIVE and GAP.
REQ-013 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-014 SHALL have port table  output  2**N  captured truth table; bit i holds f_in for vec==i.

Function
REQ-015 SHALL implement states IDLE, DRIVE, GAP and DONE, all registered.
REQ-016 IDLE with start=1 SHALL, at the next edge: enter DRIVE; latch mode; clear table; load vec with 0 (ascending) or 2**N-1 (descending); clear the dwell counter.
REQ-017 start in any state other than IDLE SHALL be ignored.
REQ-018 DRIVE SHALL hold vec for exactly DWELL cycles, counting 0..DWELL-1.
REQ-019 At count DWELL-1, the block SHALL write f_in into table[vec] at that clock edge.
REQ-020 At count DWELL-1 on the last vector (2**N-1 ascending, 0 descending), the next state SHALL be DONE.
REQ-021 At count DWELL-1 where the next vector's MSB differs from the current one and GAP>0, the next state SHALL be GAP with vec held; otherwise vec SHALL step by +1/-1 and the count SHALL reset.
REQ-022 GAP SHALL last exactly GAP cycles with vec_valid=0 and busy=1, then step vec by +1/-1 and return to DRIVE with the count at 0.
REQ-023 Midpoint detection SHALL apply in both directions (ascending 2**(N-1)-1 to 2**(N-1); descending 2**(N-1) to 2**(N-1)-1); with N=1, the 0/1 transition is the midpoint.
REQ-024 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE; table SHALL hold until the next start or rst.
REQ-025 abort=1 in DRIVE or GAP SHALL force IDLE at the next edge, with no done pulse, vec=0 and the partial table retained.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 abort and the capture edge coinciding SHALL still write the table bit.
REQ-028 Total sweep length SHALL be (2**N)*DWELL + GAP cycles.
REQ-029 done SHALL assert in the cycle after the final DRIVE cycle, i.e. start-edge + 1 + (2**N)*DWELL + GAP.
REQ-030 Counters SHALL be sized to hold max(DWELL,GAP)-1 without wrap; vec stepping SHALL never wrap past the endpoints.

Reset
REQ-031 rst=1 SHALL at the next edge force IDLE, vec=0, vec_valid=0, busy=0, done=0, table=0, counters=0 and latched mode=0, overriding start and abort.
REQ-032 rst asserted mid-sweep SHALL discard all partial results.

Verification
REQ-033 Default params, mode=0, bench drives f_in=vec[0]: start at edge k -> vec sequence 0..15, each held 5 cycles; done pulses in cycle k+93; table=16'hAAAA.
REQ-034 mode=1, f_in=(vec==4'hF): first vec=4'hF, sequence descends to 0; table=16'h8000; done at k+93.
REQ-035 Gap check: vec_valid low for exactly 12 consecutive cycles between vec 7 and vec 8 ascending, and between 8 and 7 descending; vec held during the gap.
REQ-036 start pulsed during DRIVE -> no restart, vec sequence unchanged; abort during vec=5 -> IDLE next cycle, done never pulses, table bits 0..4 retained.
REQ-037 rst asserted during GAP -> next cycle all outputs 0, table=0; subsequent start runs a full clean sweep.
REQ-038 DWELL=1, GAP=0, N=4 -> 16 consecutive vectors with no gap, vec_valid continuously high; done at k+17.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every N-bit vector for DWELL cycles,
// inserts an idle GAP at the half-table midpoint, and captures f_in per vector.
module truth_table_sweeper #(
  parameter int N     = 4,
  parameter int DWELL = 5,
  parameter int GAP   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic            abort,
  input  logic            f_in,
  output logic [N-1:0]    vec,
  output logic            vec_valid,
  output logic            busy,
  output logic            done,
  // "table" is a reserved word, so the captured truth table is table_out
  output logic [2**N-1:0] table_out
);

  localparam int TW   = 2**N;
  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [N-1:0]  VEC_MIN    = {N{1'b0}};
  localparam logic [N-1:0]  VEC_MAX    = {N{1'b1}};
  localparam logic [N-1:0]  VEC_ONE    = N'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [TW-1:0]   table_q, table_d;
  logic            vec_valid_q, vec_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [N-1:0]    next_vec_s;
  logic            last_vec_s;
  logic            mid_s;

  // Next-state, next-vector and registered-output computation
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    table_d     = table_q;
    vec_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    next_vec_s = mode_q ? (vec_q - VEC_ONE) : (vec_q + VEC_ONE);
    last_vec_s = mode_q ? (vec_q == VEC_MIN) : (vec_q == VEC_MAX);
    mid_s      = (next_vec_s[N-1] != vec_q[N-1]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_DRIVE;
          mode_d      = mode;
          table_d     = {TW{1'b0}};
          vec_d       = mode ? VEC_MAX : VEC_MIN;
          cnt_d       = CNT_ZERO;
          vec_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DRIVE: begin
        vec_valid_d = 1'b1;
        busy_d      = 1'b1;
        if (cnt_q == DWELL_LAST) begin
          table_d[vec_q] = f_in;
          cnt_d          = CNT_ZERO;
          if (last_vec_s) begin
            state_d     = S_DONE;
            vec_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else if ((GAP > 0) && mid_s) begin
            state_d     = S_GAP;
            vec_valid_d = 1'b0;
          end else begin
            vec_d = next_vec_s;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        // Abort wins over sequencing but a same-edge capture still lands
        if (abort) begin
          state_d     = S_IDLE;
          vec_d       = VEC_MIN;
          cnt_d       = CNT_ZERO;
          vec_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end else begin
          mode_d = mode_q;
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d     = S_DRIVE;
          vec_d       = next_vec_s;
          cnt_d       = CNT_ZERO;
          vec_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (abort) begin
          state_d     = S_IDLE;
          vec_d       = VEC_MIN;
          cnt_d       = CNT_ZERO;
          vec_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          mode_d = mode_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        vec_d   = VEC_MIN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= VEC_MIN;
      cnt_q       <= CNT_ZERO;
      mode_q      <= 1'b0;
      table_q     <= {TW{1'b0}};
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      table_q     <= table_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default instance (DWELL=5, GAP=12) and a fast
// instance (DWELL=1, GAP=0); per-cycle expectations come from a scoreboard queue.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode, abort, start_a, start_b;
  int          fsel;
  logic [3:0]  vec_a, vec_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b, f_a, f_b;
  logic [15:0] table_a, table_b;

  function automatic logic f_of(int sel, logic [3:0] v);
    case (sel)
      0:       return v[0];
      1:       return (v == 4'hF);
      default: return v[1] ^ v[3];
    endcase
  endfunction

  assign f_a = f_of(fsel, vec_a);
  assign f_b = f_of(fsel, vec_b);

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode), .abort(abort), .f_in(f_a),
    .vec(vec_a), .vec_valid(valid_a), .busy(busy_a), .done(done_a), .table_out(table_a)
  );

  truth_table_sweeper #(.N(4), .DWELL(1), .GAP(0)) u_fast (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode), .abort(abort), .f_in(f_b),
    .vec(vec_b), .vec_valid(valid_b), .busy(busy_b), .done(done_b), .table_out(table_b)
  );

  typedef struct {
    logic       valid;
    logic [3:0] vec;
    logic       busy;
    logic       done;
    logic       chk_vec;
  } obs_t;

  typedef struct {
    logic        fast;
    logic        mode;
    int          fsel;
    int          abort_vec;
    int          start_at;
    logic [15:0] exp_table;
    int          exp_done;
  } tv_t;

  obs_t sb[$];
  tv_t  tv[8];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one sweep, starting the cycle after the start edge
  function automatic void push_sweep(input logic m, input int dwell, input int gap, input int abort_vec);
    logic [3:0] v;
    v = 4'h0;
    for (int idx = 0; idx < 16; idx++) begin
      v = m ? 4'(15 - idx) : 4'(idx);
      if (int'(v) == abort_vec) begin
        sb.push_back('{1'b1, v, 1'b1, 1'b0, 1'b1});
        for (int k = 0; k < 3; k++) sb.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1});
        return;
      end
      for (int d = 0; d < dwell; d++) sb.push_back('{1'b1, v, 1'b1, 1'b0, 1'b1});
      if (idx == 7)
        for (int g = 0; g < gap; g++) sb.push_back('{1'b0, v, 1'b1, 1'b0, 1'b1});
    end
    sb.push_back('{1'b0, v, 1'b0, 1'b1, 1'b1});
    sb.push_back('{1'b0, v, 1'b0, 1'b0, 1'b0});
  endfunction

  task automatic run_sweep(input tv_t c);
    obs_t       e;
    int         cyc;
    int         done_cyc;
    bit         aborted;
    logic [3:0] ov;
    logic       ova, obu, odo;
    logic [15:0] otab;
    fsel = c.fsel;
    mode = c.mode;
    @(negedge clk);
    if (c.fast) start_b = 1'b1; else start_a = 1'b1;
    push_sweep(c.mode, c.fast ? 1 : 5, c.fast ? 0 : 12, c.abort_vec);
    cyc = 0; done_cyc = 0; aborted = 1'b0;
    while (sb.size() > 0) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
      e   = sb.pop_front();
      ov  = c.fast ? vec_b   : vec_a;
      ova = c.fast ? valid_b : valid_a;
      obu = c.fast ? busy_b  : busy_a;
      odo = c.fast ? done_b  : done_a;
      check($sformatf("vec_valid c%0d", cyc), 32'(ova), 32'(e.valid));
      check($sformatf("busy c%0d", cyc), 32'(obu), 32'(e.busy));
      check($sformatf("done c%0d", cyc), 32'(odo), 32'(e.done));
      if (e.chk_vec) check($sformatf("vec c%0d", cyc), 32'(ov), 32'(e.vec));
      if (odo && done_cyc == 0) done_cyc = cyc;
      if (cyc == c.start_at) begin
        mode = ~c.mode;
        if (c.fast) start_b = 1'b1; else start_a = 1'b1;
      end
      if (c.abort_vec >= 0 && !aborted && ova && int'(ov) == c.abort_vec) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
    end
    start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    otab = c.fast ? table_b : table_a;
    check("done_latency", 32'(done_cyc), 32'(c.exp_done));
    check("table", 32'(otab), 32'(c.exp_table));
  endtask

  initial begin
    int waited;
    rst = 1'b1; mode = 1'b0; abort = 1'b0; start_a = 1'b0; start_b = 1'b0; fsel = 0;

    tv[0] = '{1'b0, 1'b0, 0, -1, 0,  16'hAAAA, 93};
    tv[1] = '{1'b0, 1'b1, 1, -1, 0,  16'h8000, 93};
    tv[2] = '{1'b0, 1'b0, 2, -1, 0,  16'h33CC, 93};
    tv[3] = '{1'b0, 1'b1, 2, -1, 0,  16'h33CC, 93};
    tv[4] = '{1'b0, 1'b0, 0, -1, 30, 16'hAAAA, 93};
    tv[5] = '{1'b0, 1'b0, 0, 5,  0,  16'h000A, 0};
    tv[6] = '{1'b1, 1'b0, 0, -1, 0,  16'hAAAA, 17};
    tv[7] = '{1'b1, 1'b1, 1, -1, 0,  16'h8000, 17};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset vec", 32'(vec_a), 32'h0);
    check("reset valid/busy/done", 32'({valid_a, busy_a, done_a}), 32'h0);
    check("reset table", 32'(table_a), 32'h0);
    check("reset fast outputs", 32'({vec_b, valid_b, busy_b, done_b, table_b}), 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_sweep(tv[i]);
      repeat (2) @(negedge clk);
    end

    // Reset landing in the midpoint gap wipes everything
    fsel = 0; mode = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waited = 0;
    while (!(busy_a && !valid_a) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("gap reached", 32'(waited < 200), 32'h1);
    check("gap vec held", 32'(vec_a), 32'h7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst in gap outputs", 32'({vec_a, valid_a, busy_a, done_a}), 32'h0);
    check("rst in gap table", 32'(table_a), 32'h0);
    @(negedge clk);
    run_sweep(tv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
